// File: rtl/imm_encoder.sv
// RV32I instruction packer: fields + 32-bit immediate -> R/I/S/B/J/U words, with range checks.
// Optional LUI+ADDI load-immediate expansion enabled by defining IMM_ENCODER_LI_EXPAND_EN.
module imm_encoder #(
    parameter int SKIP_ZERO_LO = 1,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [6:0]      req_opcode,
    input  logic [2:0]      req_funct3,
    input  logic [6:0]      req_funct7,
    input  logic [4:0]      req_rd,
    input  logic [4:0]      req_rs1,
    input  logic [4:0]      req_rs2,
    input  logic [XLEN-1:0] req_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_last,
    output logic            err_valid,
    output logic [1:0]      err_code
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // IDLE: accepting | EMIT: presenting first word | EMIT2: presenting second LI word
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_EMIT2} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_out_instr;
    logic        r_out_last;
    logic [31:0] r_word2;
    logic        r_err_valid;
    logic [1:0]  r_err_code;

    logic        w_accept;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic        w_expand_ok;
    logic        w_skip_lo;
    logic [19:0] w_lui_hi;
    logic [31:0] w_lui_word;
    logic [31:0] w_addi_word;
    logic [31:0] w_word1;
    logic        w_two_words;
    logic [1:0]  w_err;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_fits12 = (&req_imm[31:11]) || !(|req_imm[31:11]);
    assign w_fits13 = (&req_imm[31:12]) || !(|req_imm[31:12]);
    assign w_fits21 = (&req_imm[31:20]) || !(|req_imm[31:20]);

    // Adding 0x800 before taking [31:12] only carries into bit 12 when imm[11] is set.
    assign w_lui_hi    = req_imm[31:12] + {19'b0, req_imm[11]};
    assign w_lui_word  = {w_lui_hi, req_rd, OP_LUI};
    assign w_addi_word = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_I_TYPE};
    assign w_skip_lo   = (SKIP_ZERO_LO != 0) && (req_imm[11:0] == 12'h000);

`ifdef IMM_ENCODER_LI_EXPAND_EN
    assign w_expand_ok = (req_opcode == OP_I_TYPE) && (req_funct3 == 3'b000) && (req_rs1 == 5'd0);
`else
    assign w_expand_ok = 1'b0;
`endif

    always_comb begin
        w_word1     = 32'h0;
        w_two_words = 1'b0;
        w_err       = 2'd0;
        case (req_opcode)
            OP_R_TYPE: w_word1 = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
            OP_I_TYPE, OP_LOAD, OP_JALR: begin
                if (w_fits12) begin
                    w_word1 = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
                end else if (w_expand_ok) begin
                    w_word1     = w_lui_word;
                    w_two_words = !w_skip_lo;
                end else begin
                    w_err = 2'd1;
                end
            end
            OP_STORE: begin
                if (w_fits12)
                    w_word1 = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
                else
                    w_err = 2'd1;
            end
            OP_BRANCH: begin
                if (req_imm[0])
                    w_err = 2'd2;
                else if (!w_fits13)
                    w_err = 2'd1;
                else
                    w_word1 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                               req_imm[4:1], req_imm[11], req_opcode};
            end
            OP_JAL: begin
                if (req_imm[0])
                    w_err = 2'd2;
                else if (!w_fits21)
                    w_err = 2'd1;
                else
                    w_word1 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                               req_rd, req_opcode};
            end
            OP_LUI, OP_AUIPC: begin
                if (req_imm[11:0] != 12'h000)
                    w_err = 2'd1;
                else
                    w_word1 = {req_imm[31:12], req_rd, req_opcode};
            end
            default: w_err = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && (w_err == 2'd0)) w_state_nxt = S_EMIT;
            S_EMIT:  if (out_ready) w_state_nxt = r_out_last ? S_IDLE : S_EMIT2;
            S_EMIT2: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_instr <= 32'h0;
            r_out_last  <= 1'b0;
            r_word2     <= 32'h0;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_err_valid <= 1'b0;
            r_err_code  <= 2'd0;
            if (w_accept) begin
                if (w_err != 2'd0) begin
                    r_err_valid <= 1'b1;
                    r_err_code  <= w_err;
                end else begin
                    r_out_instr <= w_word1;
                    r_out_last  <= !w_two_words;
                    r_word2     <= w_addi_word;
                end
            end else if ((r_state == S_EMIT) && out_ready && !r_out_last) begin
                r_out_instr <= r_word2;
                r_out_last  <= 1'b1;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign out_valid = (r_state != S_IDLE);
    assign out_instr = r_out_instr;
    assign out_last  = r_out_last;
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors push expected words/errors, a monitor pops them.
// Expectations for load-immediate expansion follow IMM_ENCODER_LI_EXPAND_EN.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err_valid;
    logic [1:0]  err_code;

    imm_encoder #(.SKIP_ZERO_LO(1), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_last(out_last), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] instr;
        logic        last;
        logic [1:0]  code;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] instr, input logic last);
        exp_t e;
        e.is_err = 1'b0; e.instr = instr; e.last = last; e.code = 2'd0;
        q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.instr = 32'h0; e.last = 1'b0; e.code = code;
        q.push_back(e);
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            n_checks++; n_errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_opcode = op; req_funct3 = f3; req_funct7 = f7;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Monitor: a handshake seen at negedge is the one the DUT takes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_word: got 0x%08h expected none", out_instr);
                end else begin
                    m_e = q.pop_front();
                    check("kind_word", 32'(m_e.is_err), 32'd0);
                    check("out_instr", out_instr, m_e.instr);
                    check("out_last", 32'(out_last), 32'(m_e.last));
                end
            end
            if (err_valid) begin
                if (q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_err: got code %0d expected none", err_code);
                end else begin
                    m_e = q.pop_front();
                    check("kind_err", 32'(m_e.is_err), 32'd1);
                    check("err_code", 32'(err_code), 32'(m_e.code));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [6:0] OPI = 7'h13, OPB = 7'h63, OPJ = 7'h6F, OPR = 7'h33;
    localparam logic [6:0] OPS = 7'h23, OPL = 7'h03, OPU = 7'h37;

    initial begin
        rst = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);

        push_word(32'hFFF00293, 1'b1); issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
        push_word(32'h00208463, 1'b1); issue(OPB, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        push_err(2'd2);                issue(OPB, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        check("rdy_after_err2", 32'(req_ready), 32'd1);
        push_err(2'd1);                issue(OPJ, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00100000);
        check("rdy_after_err1", 32'(req_ready), 32'd1);
        push_err(2'd3);                issue(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        check("rdy_after_err3", 32'(req_ready), 32'd1);
        push_word(32'h402081B3, 1'b1); issue(OPR, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF);
        push_word(32'h0020A423, 1'b1); issue(OPS, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        push_word(32'h001000EF, 1'b1); issue(OPJ, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        push_word(32'hFFFFF0EF, 1'b1); issue(OPJ, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFE);
        push_word(32'h7E209FE3, 1'b1); issue(OPB, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4094);
        push_err(2'd1);                issue(OPB, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
        push_err(2'd2);                issue(OPB, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4095);
        push_word(32'h80208063, 1'b1); issue(OPB, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFF000);
        push_word(32'h7FF00293, 1'b1); issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2047);
        push_word(32'h123452B7, 1'b1); issue(OPU, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        push_err(2'd1);                issue(OPU, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001);
        push_word(32'h8000A283, 1'b1); issue(OPL, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 32'hFFFFF800);
        push_err(2'd1);                issue(OPI, 3'd0, 7'd0, 5'd5, 5'd1, 5'd0, 32'h12345678);
        push_err(2'd1);                issue(OPS, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd2048);

`ifdef IMM_ENCODER_LI_EXPAND_EN
        push_word(32'h123452B7, 1'b0); push_word(32'h67828293, 1'b1);
        issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        push_word(32'h000012B7, 1'b0); push_word(32'h80028293, 1'b1);
        issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00000800);
        push_word(32'h000122B7, 1'b1);
        issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00012000);
`else
        push_err(2'd1); issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        push_err(2'd1); issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00000800);
        push_err(2'd1); issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00012000);
`endif

        // Backpressure: word must hold for three stalled cycles, then drain once out_ready rises.
        while (!req_ready) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        push_word(32'hFFF00293, 1'b1); issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_instr", out_instr, 32'hFFF00293);
            check("bp_last", 32'(out_last), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", 32'(out_valid), 32'd0);

        // Reset while a word is still pending: nothing further may reach the output.
        out_ready = 1'b0;
`ifdef IMM_ENCODER_LI_EXPAND_EN
        push_word(32'h123452B7, 1'b0);
        issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("emit2_instr", out_instr, 32'h67828293);
        check("emit2_last", 32'(out_last), 32'd1);
`else
        issue(OPI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
        check("emit_valid", 32'(out_valid), 32'd1);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_instr", out_instr, 32'h0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        push_word(32'h00208463, 1'b1); issue(OPB, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-side immediate extraction: packs instruction fields plus a full 32-bit immediate into legal RV32I encodings (R, I, S, B, J, U).
- Used by the debug program-buffer writer and the self-test stimulus generator.
- Accepts one request per valid/ready handshake and emits one or two 32-bit instruction words on a registered valid/ready output.
- Range-checks immediates, and optionally expands out-of-range load-immediates into LUI+ADDI pairs.

Parameters:
- SKIP_ZERO_LO, 1: when 1, an expanded load-immediate whose low 12 bits are zero emits only the LUI.
- XLEN, riscv_pkg::XLEN (32): datapath width; only 32 is supported.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  encoder can accept a request
- req_opcode  input  opcode_t (7)  target opcode
- req_funct3  input  3  funct3 field
- req_funct7  input  7  funct7 field (R-type only)
- req_rd  input  5  destination register
- req_rs1  input  5  source register 1
- req_rs2  input  5  source register 2
- req_imm  input  XLEN  signed immediate (U-type: full value, low 12 bits must be zero)
- out_valid  output  1  out_instr valid
- out_ready  input  1  consumer accepts out_instr
- out_instr  output  32  encoded instruction word
- out_last  output  1  marks final word of the current request
- err_valid  output  1  one-cycle pulse: request rejected
- err_code  output  2  1=range, 2=misaligned, 3=unsupported opcode; 0 otherwise

Behaviour:
- Single clock clk; rst is synchronous, active-high.
- Reset values: state IDLE; out_valid=0, out_instr=0, out_last=0, err_valid=0, err_code=0, req_ready=1.
- FSM states: IDLE, EMIT, EMIT2.
- req_ready is high only in IDLE. A handshake is req_valid && req_ready.
- Accept in cycle N: the first word is registered and out_valid=1 in cycle N+1 (latency 1). No combinational path from req_* to out_*.
- IDLE -> EMIT on an accepted legal request.
- IDLE stays IDLE on an accepted illegal request: err_valid=1 and err_code set in N+1 for exactly one cycle, no output word.
- EMIT: out_instr, out_last and out_valid are held stable while out_ready=0.
  - On out_ready: if out_last, go to IDLE; else load the second word and go to EMIT2.
- EMIT2: holds the second word with out_last=1; on out_ready, go to IDLE.
- The next request is accepted at the earliest one cycle after the final word's handshake (IDLE re-entry). No overlap.
- Encoding uses the standard RV32I bit placement per format.
  - B format: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7].
  - J format: imm[20|10:1|11|19:12] in inst[31:12].
  - Fields not used by a format are forced to 0.
- Legality checks:
  - I/LOAD/JALR/S: -2048..2047.
  - B: -4096..4094.
  - J: -1048576..1048574.
  - B/J with imm[0]=1 give err_code 2 (the misaligned check takes priority over the range check).
  - U with imm[11:0]!=0 gives err_code 1.
  - OP_R_TYPE ignores req_imm.
  - Any other opcode gives err_code 3.
- Reset mid-operation: the pending second word is dropped, the FSM returns to IDLE, and all outputs take their reset values in the next cycle.

Optional Feature:
- Macro IMM_ENCODER_LI_EXPAND_EN.
- With the macro defined: OP_I_TYPE, funct3=000 (ADDI), rs1=x0, imm outside the 12-bit range expands to two words.
  - Word 1: LUI rd, hi, where hi = (imm + 0x800)[31:12], computed modulo 2^32.
  - Word 2: ADDI rd, rd, imm[11:0].
  - out_last=0 on the first word.
  - If imm[11:0]==0 and SKIP_ZERO_LO=1, only the LUI is emitted, with out_last=1.
- Without the macro: the same request gets err_code 1, and EMIT2 is never reachable.

Test Plan:
- ADDI rd=5, rs1=0, imm=-1 -> one word 0xFFF00293, out_last=1, no error.
- BEQ rs1=1, rs2=2, imm=8 -> 0x00208463. BEQ with imm=7 -> err_valid pulse, err_code=2, no out_valid.
- JAL rd=1, imm=0x100000 -> err_code=1. Opcode 0x7F -> err_code=3. req_ready stays high after each rejection.
- LI_EXPAND_EN, ADDI rd=5, rs1=0, imm=0x12345678 -> 0x123452B7 (last=0), then 0x67828293 (last=1). imm=0x800 -> 0x000012B7, then 0x80028293.
- Backpressure: hold out_ready=0 for 3 cycles during EMIT -> out_instr/out_last stable, req_ready=0 throughout; word advances on the first cycle out_ready=1.
- Assert rst while in EMIT2 (imm=0x12345678) -> next cycle out_valid=0, req_ready=1, second word never appears.
